// File: rtl/mem_readout_sequencer.sv
// Frame readout sequencer: drains every non-empty memory block once per frame in priority order.
// Optional round-robin priority rotation is enabled by defining MEM_READOUT_ROUND_ROBIN_EN.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | counts latched; one settle cycle, then grant first pending block or finish
// READ  | issuing read requests for the granted block
module mem_readout_sequencer #(
    parameter int NCH  = 12,
    parameter int AW   = 6,
    parameter int SELW = $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NCH*(AW+1)-1:0]   nent,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [AW-1:0]           rd_addr,
    output logic [SELW-1:0]         sel_enc,
    output logic [NCH-1:0]          sel,
    output logic                    last,
    output logic                    done,
    output logic                    none,
    output logic                    overrun
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CMAX = CW'(1) << AW;

    typedef enum logic [1:0] {IDLE, SCAN, READ} state_t;

    state_t          state_q, state_d;
    logic            scan_ph_q, scan_ph_d;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [CW-1:0]   cnt_q [NCH];
    logic [CW-1:0]   cnt_d [NCH];
    logic            rd_valid_q, rd_valid_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [SELW-1:0] sel_enc_q, sel_enc_d;
    logic [NCH-1:0]  sel_q, sel_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            none_q, none_d;
    logic            overrun_q, overrun_d;

    logic [CW-1:0]   lat_cnt [NCH];
    logic [NCH-1:0]  lat_pend;
    logic            load;
    logic            accept;
    logic            at_end;
    logic [AW-1:0]   addr_inc;
    logic [CW-1:0]   cur_cnt;
    logic [NCH-1:0]  others;
    logic [SELW-1:0] base;
    logic [SELW-1:0] g_scan;
    logic [SELW-1:0] g_next;

`ifdef MEM_READOUT_ROUND_ROBIN_EN
    logic [SELW-1:0] rr_q, rr_d;
    logic [SELW-1:0] base_q, base_d;
`endif

    // First set bit of mask, searching base, base+1, ... with wrap at NCH.
    function automatic logic [SELW-1:0] pick(input logic [NCH-1:0] mask, input logic [SELW-1:0] base_i);
        logic [SELW-1:0] g;
        logic [SELW-1:0] ix;
        int              idx;
        g = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(base_i) + k;
            if (idx >= NCH) idx = idx - NCH;
            ix = SELW'(idx);
            if (mask[ix]) g = ix;
        end
        return g;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] g);
        return NCH'(1) << g;
    endfunction

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            lat_cnt[i]  = (nent[i*CW +: CW] > CMAX) ? CMAX : nent[i*CW +: CW];
            lat_pend[i] = (nent[i*CW +: CW] != '0);
        end
    end

`ifdef MEM_READOUT_ROUND_ROBIN_EN
    assign base = base_q;
`else
    assign base = '0;
`endif

    assign accept   = rd_valid_q & rd_ready;
    assign cur_cnt  = cnt_q[sel_enc_q];
    assign addr_inc = rd_addr_q + 1'b1;
    assign at_end   = ({1'b0, rd_addr_q} == cur_cnt - 1'b1);
    assign others   = pending_q & ~onehot(sel_enc_q);
    assign g_scan   = pick(pending_q, base);
    assign g_next   = pick(others, base);

    always_comb begin
        state_d    = state_q;
        scan_ph_d  = scan_ph_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        sel_enc_d  = sel_enc_q;
        last_d     = last_q;
        done_d     = 1'b0;
        none_d     = 1'b0;
        overrun_d  = 1'b0;
        load       = 1'b0;
`ifdef MEM_READOUT_ROUND_ROBIN_EN
        rr_d       = rr_q;
        base_d     = base_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) load = 1'b1;
            end
            SCAN: begin
                if (start) begin
                    overrun_d = 1'b1;
                    load      = 1'b1;
                end else if (!scan_ph_q) begin
                    scan_ph_d = 1'b1;
                end else if (pending_q == '0) begin
                    done_d  = 1'b1;
                    none_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = '0;
                    sel_enc_d  = g_scan;
                    last_d     = (cnt_q[g_scan] == CW'(1)) &&
                                 ((pending_q & ~onehot(g_scan)) == '0);
                    state_d    = READ;
                end
            end
            READ: begin
                // A start that lands on the final transfer completes the frame instead of aborting it.
                if (start && !(accept && at_end && (others == '0))) begin
                    overrun_d  = 1'b1;
                    rd_valid_d = 1'b0;
                    last_d     = 1'b0;
                    load       = 1'b1;
                end else if (accept) begin
                    if (!at_end) begin
                        rd_addr_d = addr_inc;
                        last_d    = ({1'b0, addr_inc} == cur_cnt - 1'b1) && (others == '0);
                    end else begin
                        pending_d[sel_enc_q] = 1'b0;
                        if (others != '0) begin
                            rd_addr_d = '0;
                            sel_enc_d = g_next;
                            last_d    = (cnt_q[g_next] == CW'(1)) &&
                                        ((others & ~onehot(g_next)) == '0);
                        end else begin
                            rd_valid_d = 1'b0;
                            last_d     = 1'b0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                            if (start) load = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cnt_d     = lat_cnt;
            pending_d = lat_pend;
            scan_ph_d = 1'b0;
            state_d   = SCAN;
`ifdef MEM_READOUT_ROUND_ROBIN_EN
            base_d    = rr_q;
            rr_d      = (rr_q == SELW'(NCH - 1)) ? '0 : rr_q + 1'b1;
`endif
        end

        sel_d = rd_valid_d ? onehot(sel_enc_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_ph_q  <= 1'b0;
            pending_q  <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            sel_enc_q  <= '0;
            sel_q      <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            none_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef MEM_READOUT_ROUND_ROBIN_EN
            rr_q       <= '0;
            base_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            scan_ph_q  <= scan_ph_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            sel_enc_q  <= sel_enc_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            done_q     <= done_d;
            none_q     <= none_d;
            overrun_q  <= overrun_d;
`ifdef MEM_READOUT_ROUND_ROBIN_EN
            rr_q       <= rr_d;
            base_q     <= base_d;
`endif
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_addr  = rd_addr_q;
    assign sel_enc  = sel_enc_q;
    assign sel      = sel_q;
    assign last     = last_q;
    assign done     = done_q;
    assign none     = none_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_mem_readout_sequencer.sv
// Randomized bench for mem_readout_sequencer: expected request stream per frame is built as a queue
// from the latched counts and priority order, then matched against every accepted transfer.
module tb_mem_readout_sequencer;

    localparam int NCH  = 12;
    localparam int AW   = 6;
    localparam int SELW = $clog2(NCH);
    localparam int CW   = AW + 1;
    localparam int MAXC = 1 << AW;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [NCH*CW-1:0]     nent = '0;
    logic                  rd_ready = 1'b0;
    logic                  rd_valid;
    logic [AW-1:0]         rd_addr;
    logic [SELW-1:0]       sel_enc;
    logic [NCH-1:0]        sel;
    logic                  last;
    logic                  done;
    logic                  none;
    logic                  overrun;

    mem_readout_sequencer #(.NCH(NCH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .nent     (nent),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .sel_enc  (sel_enc),
        .sel      (sel),
        .last     (last),
        .done     (done),
        .none     (none),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ch;
        bit lst;
    } req_t;

    req_t exp_q[$];
    int   cnt_m [NCH];
    int   rr_p = 0;
    int   exp_sum;
    bit   exp_none;
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected stream: blocks in priority order from the frame's base, entries 0..min(cnt,2^AW)-1.
    task automatic load_frame();
        int ch;
        int c;
        req_t r;
        exp_q.delete();
        exp_sum = 0;
        for (int k = 0; k < NCH; k++) begin
            ch = (rr_p + k) % NCH;
            c  = (cnt_m[ch] > MAXC) ? MAXC : cnt_m[ch];
            for (int a = 0; a < c; a++) begin
                r.addr = a;
                r.ch   = ch;
                r.lst  = 1'b0;
                exp_q.push_back(r);
            end
            exp_sum += c;
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].lst = 1'b1;
        exp_none = (exp_sum == 0);
        for (int i = 0; i < NCH; i++) nent[i*CW +: CW] = CW'(cnt_m[i]);
`ifdef MEM_READOUT_ROUND_ROBIN_EN
        rr_p = (rr_p + 1) % NCH;
`endif
    endtask

    // Called at a negedge; returns at the negedge after the start is sampled.
    task automatic pulse_start();
        load_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
    endtask

    task automatic watch_frame(input int mode, input bit ovr0, input bit done0, input logic [31:0] pat);
        int cyc = 0;
        bit fin = 1'b0;
        bit rdy;
        while (!fin && cyc < 3000) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 0) begin
                chk("overrun_at_start", overrun, ovr0);
                chk("done_at_start", done, done0);
                chk("valid_at_start", rd_valid, 0);
            end else begin
                chk("no_overrun", overrun, 0);
            end
            if (cyc >= 2 && done) begin
                chk("entries_left", exp_q.size(), 0);
                chk("none", none, exp_none);
                chk("valid_at_done", rd_valid, 0);
                if (mode == 0) chk("latency", cyc, 2 + exp_sum);
                fin = 1'b1;
            end else if (cyc >= 1) begin
                chk("no_done", done, 0);
                chk("no_none", none, 0);
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_request", rd_valid, 0);
                end else begin
                    chk("rd_addr", rd_addr, exp_q[0].addr);
                    chk("sel_enc", sel_enc, exp_q[0].ch);
                    chk("sel", sel, 32'(1) << exp_q[0].ch);
                    chk("last", last, exp_q[0].lst);
                end
            end else begin
                chk("sel_idle", sel, 0);
            end
            if (!fin) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = pat[cyc % 32];
                endcase
                rd_ready = rdy;
                if (rd_valid && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            cyc++;
        end
        if (!fin) chk("frame_timeout", done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_addr"}, rd_addr, 0);
        chk({tag, "_sel_enc"}, sel_enc, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_none"}, none, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int w;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Mixed blocks with gaps, ready held high.
        clear_counts();
        cnt_m[0] = 2; cnt_m[3] = 1; cnt_m[11] = 3;
        pulse_start();
        watch_frame(0, 0, 0, '1);

        // Empty frame.
        @(negedge clk);
        clear_counts();
        pulse_start();
        watch_frame(0, 0, 0, '1);

        // Ready 1,0,0,1 across the start of ch3.
        @(negedge clk);
        clear_counts();
        cnt_m[0] = 1; cnt_m[3] = 2;
        pulse_start();
        watch_frame(2, 0, 0, 32'hFFFF_FFE7);

        // Clamp to 2^AW.
        @(negedge clk);
        clear_counts();
        cnt_m[2] = MAXC + 5; cnt_m[9] = 1;
        pulse_start();
        watch_frame(0, 0, 0, '1);

        // Abort during ch5.
        @(negedge clk);
        clear_counts();
        cnt_m[1] = 3; cnt_m[5] = 10;
        rd_ready = 1'b1;
        pulse_start();
        w = 0;
        while (!(rd_valid && sel_enc == SELW'(5)) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("reach_ch5", sel_enc, 5);
        clear_counts();
        cnt_m[4] = 2; cnt_m[7] = 3;
        pulse_start();
        watch_frame(0, 1, 0, '1);

        // Start coincident with the final transfer.
        @(negedge clk);
        clear_counts();
        cnt_m[2] = 3; cnt_m[7] = 2;
        rd_ready = 1'b1;
        pulse_start();
        repeat (6) @(negedge clk);
        chk("final_valid", rd_valid, 1);
        chk("final_last", last, 1);
        clear_counts();
        cnt_m[6] = 2;
        pulse_start();
        watch_frame(0, 0, 1, '1);

        // All channels one entry, three frames.
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) cnt_m[i] = 1;
            pulse_start();
            watch_frame(0, 0, 0, '1);
        end

        // Reset pulse mid-frame.
        @(negedge clk);
        clear_counts();
        cnt_m[4] = 20;
        rd_ready = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk);
        chk("pre_reset_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rr_p = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("after_reset_done", done, 0);
            chk("after_reset_valid", rd_valid, 0);
        end
        for (int i = 0; i < NCH; i++) cnt_m[i] = 1;
        pulse_start();
        watch_frame(0, 0, 0, '1);

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            int r;
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                r = $urandom_range(0, 99);
                if (r < 50)      cnt_m[i] = 0;
                else if (r < 90) cnt_m[i] = $urandom_range(1, 4);
                else if (r < 97) cnt_m[i] = $urandom_range(5, 20);
                else             cnt_m[i] = $urandom_range(60, 127);
            end
            pulse_start();
            watch_frame($urandom_range(0, 1), 0, 0, '1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
